// File: rtl/seven_segment_animator_if.sv
// Control and segment-data bundle between the IO top level and the animator.
interface seven_segment_animator_if #(
  parameter int DIGITS     = 4,
  parameter int STEP_WIDTH = 24
);
  logic                    run;
  logic                    blank;
  logic                    restart;
  logic [1:0]              mode;
  logic [STEP_WIDTH-1:0]   step_period;
  logic [7*DIGITS-1:0]     segments;
  logic                    step_pulse;
  logic                    cycle_done;

  modport master (
    output run, blank, restart, mode, step_period,
    input  segments, step_pulse, cycle_done
  );

  modport slave (
    input  run, blank, restart, mode, step_period,
    output segments, step_pulse, cycle_done
  );
endinterface

// File: rtl/seven_segment_animator.sv
// Self-timed seven-segment animation engine: a step timer advances a position
// register whose value is decoded into one of four animation patterns.
//
// Modes: 0 = figure-8 on every digit, 1 = figure-8 staggered by one frame per
// digit, 2 = single lit segment chasing the display perimeter, 3 = full blink.
module seven_segment_animator #(
  parameter int DIGITS     = 4,
  parameter int STEP_WIDTH = 24
) (
  input logic                    clk,
  input logic                    rst,
  seven_segment_animator_if.slave bus
);

  localparam int RING_LEN = 2 * DIGITS + 4;
  localparam int POS_W    = ($clog2(RING_LEN) > 3) ? $clog2(RING_LEN) : 3;

  logic [STEP_WIDTH-1:0] timer;
  logic [POS_W-1:0]      pos;
  logic [POS_W-1:0]      last_pos;
  logic [1:0]            mode_q;
  logic [7*DIGITS-1:0]   decode;
  logic [7*DIGITS-1:0]   segments_q;
  logic                  step_pulse_q;
  logic                  cycle_done_q;
  logic [6:0]            dig;
  int                    p;

  // Figure-8 frame k as {g,f,e,d,c,b,a}.
  function automatic logic [6:0] fig8(input logic [2:0] k);
    logic [6:0] f;
    case (k)
      3'd0:    f = 7'h60;
      3'd1:    f = 7'h44;
      3'd2:    f = 7'h0C;
      3'd3:    f = 7'h18;
      3'd4:    f = 7'h50;
      3'd5:    f = 7'h42;
      3'd6:    f = 7'h03;
      default: f = 7'h21;
    endcase
    return f;
  endfunction

  // Last valid position of the sequence for the active mode.
  always_comb begin
    last_pos = POS_W'(7);
    case (mode_q)
      2'd2:    last_pos = POS_W'(RING_LEN - 1);
      2'd3:    last_pos = POS_W'(1);
      default: last_pos = POS_W'(7);
    endcase
  end

  // Pattern decode of (mode_q, pos); unreachable positions decode to all-off.
  always_comb begin
    decode = '0;
    dig    = 7'h00;
    p      = int'(pos);
    for (int i = 0; i < DIGITS; i++) begin
      dig = 7'h00;
      case (mode_q)
        2'd0: if (p < 8) dig = fig8(pos[2:0]);
        2'd1: if (p < 8) dig = fig8(3'((p + i) % 8));
        2'd2: begin
          // Perimeter: top row left->right, right edge down, bottom row
          // right->left, left edge up.
          if (p < DIGITS) begin
            if (i == DIGITS - 1 - p) dig[0] = 1'b1;
          end else if (p == DIGITS) begin
            if (i == 0) dig[1] = 1'b1;
          end else if (p == DIGITS + 1) begin
            if (i == 0) dig[2] = 1'b1;
          end else if (p < 2 * DIGITS + 2) begin
            if (i == p - (DIGITS + 2)) dig[3] = 1'b1;
          end else if (p == 2 * DIGITS + 2) begin
            if (i == DIGITS - 1) dig[4] = 1'b1;
          end else if (p == 2 * DIGITS + 3) begin
            if (i == DIGITS - 1) dig[5] = 1'b1;
          end
        end
        default: if (p == 0) dig = 7'h7F;
      endcase
      decode[7*i +: 7] = dig;
    end
  end

  // Step timer, position sequencing, mode resync and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      pos          <= '0;
      mode_q       <= 2'd0;
      segments_q   <= '0;
      step_pulse_q <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      step_pulse_q <= 1'b0;
      cycle_done_q <= 1'b0;
      segments_q   <= bus.blank ? '0 : decode;
      if (bus.restart || (bus.mode != mode_q)) begin
        mode_q <= bus.mode;
        pos    <= '0;
        timer  <= '0;
      end else if (bus.run) begin
        if (timer == bus.step_period) begin
          timer        <= '0;
          step_pulse_q <= 1'b1;
          if (pos == last_pos) begin
            pos          <= '0;
            cycle_done_q <= 1'b1;
          end else begin
            pos <= pos + POS_W'(1);
          end
        end else begin
          // A period lowered below the running count rolls over with no step.
          timer <= timer + STEP_WIDTH'(1);
        end
      end
    end
  end

  assign bus.segments   = segments_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_seven_segment_animator.sv
// Bench for seven_segment_animator: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model.
module tb_seven_segment_animator;

  localparam int D    = 4;
  localparam int SW   = 24;
  localparam int SEGW = 7 * D;

  localparam logic [6:0] FIG [8] = '{7'h60, 7'h44, 7'h0C, 7'h18,
                                     7'h50, 7'h42, 7'h03, 7'h21};
  localparam int RING_EXP [12] = '{21, 14, 7, 0, 1, 2, 3, 10, 17, 24, 25, 26};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int   ring[$];
  int   m_mode;
  int   m_pos;
  int   m_timer;

  seven_segment_animator_if #(.DIGITS(D), .STEP_WIDTH(SW)) sif ();

  seven_segment_animator #(.DIGITS(D), .STEP_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int seq_len(input int md);
    if (md == 2) return ring.size();
    if (md == 3) return 2;
    return 8;
  endfunction

  // Whole-display picture for a given mode and position.
  function automatic logic [SEGW-1:0] ref_frame(input int md, input int ps);
    logic [SEGW-1:0] r;
    r = '0;
    case (md)
      0: if (ps < 8) for (int i = 0; i < D; i++) r[7*i +: 7] = FIG[ps];
      1: if (ps < 8) for (int i = 0; i < D; i++) r[7*i +: 7] = FIG[(ps + i) % 8];
      2: if (ps < ring.size()) r[ring[ps]] = 1'b1;
      default: if (ps == 0) r = '1;
    endcase
    return r;
  endfunction

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    logic [SEGW-1:0] nseg;
    logic            nsp;
    logic            ncd;
    nsp = 1'b0;
    ncd = 1'b0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_timer = 0; nseg = '0;
    end else begin
      nseg = sif.blank ? '0 : ref_frame(m_mode, m_pos);
      if (sif.restart || int'(sif.mode) != m_mode) begin
        m_mode = int'(sif.mode); m_pos = 0; m_timer = 0;
      end else if (sif.run) begin
        if (m_timer == int'(sif.step_period)) begin
          m_timer = 0;
          nsp = 1'b1;
          if (m_pos == seq_len(m_mode) - 1) begin
            m_pos = 0; ncd = 1'b1;
          end else begin
            m_pos++;
          end
        end else begin
          m_timer = (m_timer + 1) % (1 << SW);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("segments",   64'(sif.segments),   64'(nseg));
    chk("step_pulse", 64'(sif.step_pulse), 64'(nsp));
    chk("cycle_done", 64'(sif.cycle_done), 64'(ncd));
  endtask

  initial begin
    int cd_count;
    bit reached;
    logic [SEGW-1:0] all60;
    checks = 0;
    errors = 0;
    all60  = {D{7'h60}};

    for (int k = 0; k < D; k++) ring.push_back(7 * (D - 1 - k));
    ring.push_back(1);
    ring.push_back(2);
    for (int k = 0; k < D; k++) ring.push_back(7 * k + 3);
    ring.push_back(7 * (D - 1) + 4);
    ring.push_back(7 * (D - 1) + 5);

    rst = 1'b1;
    sif.run = 1'b0; sif.blank = 1'b0; sif.restart = 1'b0;
    sif.mode = 2'd0; sif.step_period = '0;
    m_mode = 0; m_pos = 0; m_timer = 0;
    #2;
    tick();
    tick();
    chk("reset_segments", 64'(sif.segments), 64'd0);

    // Mode 0, step every 3 cycles.
    rst = 1'b0; sif.run = 1'b1; sif.step_period = SW'(2);
    tick();
    chk("m0_first_frame", 64'(sif.segments), 64'(all60));
    cd_count = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (sif.cycle_done) cd_count++;
    end
    chk("m0_cycle_done_per_24", 64'(cd_count), 64'd1);

    // Mode 1, one step per cycle.
    sif.mode = 2'd1; sif.step_period = '0;
    tick();
    tick();
    chk("m1_pos0", 64'(sif.segments), 64'({7'h18, 7'h0C, 7'h44, 7'h60}));
    tick();
    chk("m1_pos1", 64'(sif.segments), 64'({7'h50, 7'h18, 7'h0C, 7'h44}));

    // Mode 2 perimeter chase.
    sif.mode = 2'd2;
    tick();
    for (int k = 0; k < 12; k++) begin
      logic [SEGW-1:0] one;
      tick();
      one = '0;
      one[RING_EXP[k]] = 1'b1;
      chk("m2_ring_bit", 64'(sif.segments), 64'(one));
    end
    chk("m2_wrap_cycle_done", 64'(sif.cycle_done), 64'd1);

    // Mid-sequence switch to blink while halted.
    sif.mode = 2'd0;
    tick();
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      if (m_pos == 5) reached = 1'b1;
      else tick();
    end
    chk("reach_pos5", 64'(reached), 64'd1);
    sif.run = 1'b0; sif.mode = 2'd3;
    tick();
    chk("m3_switch_no_step", 64'(sif.step_pulse), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("m3_hold_all_on", 64'(sif.segments), 64'({SEGW{1'b1}}));
    end
    sif.run = 1'b1;
    tick();
    tick();

    // Blank for three cycles during mode 0 stepping.
    sif.mode = 2'd0; sif.step_period = SW'(2); sif.restart = 1'b1;
    tick();
    sif.restart = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    sif.blank = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("blank_off", 64'(sif.segments), 64'd0);
    end
    sif.blank = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    // Restart coincident with a due step.
    sif.step_period = '0;
    tick();
    tick();
    sif.restart = 1'b1;
    tick();
    chk("restart_no_step", 64'(sif.step_pulse), 64'd0);
    sif.restart = 1'b0;
    tick();
    chk("restart_pos0", 64'(sif.segments), 64'(all60));

    // Reset mid-run.
    rst = 1'b1;
    tick();
    chk("midrun_rst_seg", 64'(sif.segments), 64'd0);
    rst = 1'b0;

    // Randomized traffic.
    sif.restart = 1'b1;
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom % 300) == 0;
      sif.restart = ($urandom % 40) == 0;
      if (sif.restart) sif.step_period = SW'($urandom_range(0, 3));
      if (($urandom % 60) == 0) sif.mode = 2'($urandom % 4);
      sif.run     = ($urandom % 8) != 0;
      sif.blank   = ($urandom % 10) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
